// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
// The optional stall counter (FETCH_STALL_COUNT_EN) uses the saturating helper below.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam int FETCH_DEPTH = 2;
  localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);
  localparam logic [FETCH_CNT_W-1:0] FETCH_DEPTH_CNT = FETCH_CNT_W'(FETCH_DEPTH);
  localparam int STALL_W = 16;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] value);
    logic [STALL_W-1:0] result;
    if (value == {STALL_W{1'b1}}) begin
      result = value;
    end else begin
      result = value + {{(STALL_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO; slot 0 is the head and drives decode straight
// from registers, so nothing downstream sees a path from the pop request.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [ADDRESS_WIDTH-1:0] push_pc_i,
  input  logic [DATA_WIDTH-1:0]    push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [FETCH_CNT_W-1:0]   count_o,
  output logic                     head_valid_o,
  output logic [ADDRESS_WIDTH-1:0] head_pc_o,
  output logic [DATA_WIDTH-1:0]    head_data_o
);

  logic [FETCH_DEPTH-1:0]   valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0] pc_q   [FETCH_DEPTH];
  logic [ADDRESS_WIDTH-1:0] pc_d   [FETCH_DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [FETCH_DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [FETCH_DEPTH];
  logic                     pop_s;

  assign pop_s = pop_i && valid_q[0];

  // Slot update: flush wins over everything, a pop shifts slot 1 forward.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (pop_s) begin
      valid_d[0] = valid_q[1];
      pc_d[0]    = pc_q[1];
      data_d[0]  = data_q[1];
      valid_d[1] = 1'b0;
      if (push_i) begin
        if (valid_q[1]) begin
          valid_d[1] = 1'b1;
          pc_d[1]    = push_pc_i;
          data_d[1]  = push_data_i;
        end else begin
          valid_d[0] = 1'b1;
          pc_d[0]    = push_pc_i;
          data_d[0]  = push_data_i;
        end
      end else begin
        valid_d[1] = 1'b0;
      end
    end else if (push_i) begin
      if (!valid_q[0]) begin
        valid_d[0] = 1'b1;
        pc_d[0]    = push_pc_i;
        data_d[0]  = push_data_i;
      end else begin
        valid_d[1] = 1'b1;
        pc_d[1]    = push_pc_i;
        data_d[1]  = push_data_i;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign count_o      = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
  assign head_valid_o = valid_q[0];
  assign head_pc_o    = pc_q[0];
  assign head_data_o  = data_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding read, 2-entry buffer toward decode.
// Define FETCH_STALL_COUNT_EN to add the saturating stall_count output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] pc_value,
  output logic                     pc_advance,
  input  logic                     flush,
  output logic                     mem_read,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_valid,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr_data,
`ifdef FETCH_STALL_COUNT_EN
  output logic [STALL_W-1:0]       stall_count,
`endif
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [FETCH_CNT_W-1:0]   count_s;
  logic                     issue_s;
  logic                     push_s;

  // reset_n gates the request so nothing is driven while reset is held.
  assign issue_s = (state_q == IDLE) && reset_n && !flush && (count_s < FETCH_DEPTH_CNT);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = mem_valid ? IDLE : DROP;
        end else if (mem_valid) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        if (mem_valid) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request strobes and buffer push.
  always_comb begin
    mem_read    = 1'b0;
    pc_advance  = 1'b0;
    mem_address = '0;
    push_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          mem_read    = 1'b1;
          pc_advance  = 1'b1;
          mem_address = pc_value;
        end else begin
          mem_read    = 1'b0;
        end
      end
      WAIT: begin
        if (mem_valid && !flush) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      DROP:    push_s = 1'b0;
      default: push_s = 1'b0;
    endcase
  end

  // Remember the issued address so the response can be tagged with it.
  always_comb begin
    if (issue_s) begin
      addr_d = pc_value;
    end else begin
      addr_d = addr_q;
    end
  end

  // Issued-address register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  fetch_buffer #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_buffer (
    .clock        (clock),
    .reset_n      (reset_n),
    .push_i       (push_s),
    .push_pc_i    (addr_q),
    .push_data_i  (mem_data),
    .pop_i        (instr_ready),
    .flush_i      (flush),
    .count_o      (count_s),
    .head_valid_o (instr_valid),
    .head_pc_o    (instr_pc),
    .head_data_o  (instr_data)
  );

`ifdef FETCH_STALL_COUNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall cycles: head offered but not taken; flush restarts the count.
  always_comb begin
    if (flush) begin
      stall_d = '0;
    end else if (instr_valid && !instr_ready) begin
      stall_d = sat_inc(stall_q);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
